lsu_port_arbiter: RTL and testbench

Two-port front end that shares the single LSU (byte-banked RAM with one-cycle read latency) between two requesters, e.g. pipeline data port (port 0) and debug/DMA port (port 1). Each port uses a valid/ready request channel and a valid/ready response channel. The block does round-robin arbitration, checks alignment and dtype, and sequences each access as accept → access → respond. It returns read data or a write acknowledge with an error flag.

---
 rtl/lsu_port_arbiter.sv | 139 +++++++++++++
 tb/tb_lsu_port_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_port_arbiter.sv
// rtl/lsu_port_arbiter.sv - two-port round-robin front end sharing one byte-banked LSU
// Each access runs accept -> ACCESS -> WAIT -> RESPOND; one transaction in flight.
module lsu_port_arbiter #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DTYPE_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   p0_req_valid,
  output logic                   p0_req_ready,
  input  logic [ADDR_WIDTH-1:0]  p0_req_addr,
  input  logic [DATA_WIDTH-1:0]  p0_req_wdata,
  input  logic                   p0_req_we,
  input  logic [DTYPE_WIDTH-1:0] p0_req_dtype,
  output logic                   p0_rsp_valid,
  input  logic                   p0_rsp_ready,
  output logic [DATA_WIDTH-1:0]  p0_rsp_rdata,
  output logic                   p0_rsp_err,
  input  logic                   p1_req_valid,
  output logic                   p1_req_ready,
  input  logic [ADDR_WIDTH-1:0]  p1_req_addr,
  input  logic [DATA_WIDTH-1:0]  p1_req_wdata,
  input  logic                   p1_req_we,
  input  logic [DTYPE_WIDTH-1:0] p1_req_dtype,
  output logic                   p1_rsp_valid,
  input  logic                   p1_rsp_ready,
  output logic [DATA_WIDTH-1:0]  p1_rsp_rdata,
  output logic                   p1_rsp_err,
  output logic [ADDR_WIDTH-1:0]  lsu_addr_o,
  output logic [DATA_WIDTH-1:0]  lsu_data_o,
  output logic                   lsu_we_o,
  output logic [DTYPE_WIDTH-1:0] lsu_dtype_o,
  input  logic [DATA_WIDTH-1:0]  lsu_data_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESPOND} state_t;

  state_t                 state, state_next;
  logic                   ptr;
  logic                   gnt_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   we_q;
  logic [DTYPE_WIDTH-1:0] dtype_q;
  logic                   err_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   rsp_err_q;

  logic                   gnt_sel;
  logic                   accept;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DTYPE_WIDTH-1:0] sel_dtype;
  logic                   sel_err;
  logic                   rsp_ready_sel;

  // Pointer only matters on contention; a lone requester always wins.
  assign gnt_sel   = (p0_req_valid && p1_req_valid) ? ptr : p1_req_valid;
  assign accept    = (state == IDLE) && (p0_req_valid || p1_req_valid) && !reset;
  assign sel_addr  = gnt_sel ? p1_req_addr : p0_req_addr;
  assign sel_dtype = gnt_sel ? p1_req_dtype : p0_req_dtype;

  assign sel_err = (sel_dtype > DTYPE_WIDTH'(4)) ||
                   (((sel_dtype == DTYPE_WIDTH'(1)) || (sel_dtype == DTYPE_WIDTH'(4))) && sel_addr[0]) ||
                   ((sel_dtype == DTYPE_WIDTH'(2)) && (sel_addr[1:0] != 2'b00));

  assign p0_req_ready  = accept && !gnt_sel;
  assign p1_req_ready  = accept && gnt_sel;
  assign rsp_ready_sel = gnt_q ? p1_rsp_ready : p0_rsp_ready;

  assign p0_rsp_valid = (state == RESPOND) && !gnt_q;
  assign p1_rsp_valid = (state == RESPOND) && gnt_q;
  assign p0_rsp_rdata = gnt_q ? '0 : rdata_q;
  assign p1_rsp_rdata = gnt_q ? rdata_q : '0;
  assign p0_rsp_err   = !gnt_q && rsp_err_q;
  assign p1_rsp_err   = gnt_q && rsp_err_q;

  always_comb begin
    state_next  = state;
    lsu_addr_o  = '0;
    lsu_data_o  = '0;
    lsu_we_o    = 1'b0;
    lsu_dtype_o = DTYPE_WIDTH'(2);
    case (state)
      IDLE: begin
        if (accept) state_next = ACCESS;
      end
      ACCESS: begin
        lsu_addr_o  = addr_q;
        lsu_data_o  = wdata_q;
        lsu_dtype_o = dtype_q;
        // Reset in this cycle must not let the store commit.
        lsu_we_o    = we_q && !err_q && !reset;
        state_next  = WAIT;
      end
      WAIT: begin
        lsu_addr_o  = addr_q;
        lsu_data_o  = wdata_q;
        lsu_dtype_o = dtype_q;
        state_next  = RESPOND;
      end
      RESPOND: begin
        if (rsp_ready_sel) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      dtype_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        gnt_q   <= gnt_sel;
        ptr     <= !gnt_sel;
        addr_q  <= sel_addr;
        wdata_q <= gnt_sel ? p1_req_wdata : p0_req_wdata;
        we_q    <= gnt_sel ? p1_req_we : p0_req_we;
        dtype_q <= sel_dtype;
        err_q   <= sel_err;
      end
      if (state == WAIT) begin
        rdata_q   <= (!we_q && !err_q) ? lsu_data_i : '0;
        rsp_err_q <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// tb/tb_lsu_port_arbiter.sv - randomized bench for lsu_port_arbiter with LSU and shadow-memory models
module tb_lsu_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic          p0_req_valid = 0, p0_req_ready, p0_req_we = 0, p0_rsp_valid, p0_rsp_ready = 1, p0_rsp_err;
  logic [AW-1:0] p0_req_addr = 0;
  logic [DW-1:0] p0_req_wdata = 0, p0_rsp_rdata;
  logic [TW-1:0] p0_req_dtype = 0;
  logic          p1_req_valid = 0, p1_req_ready, p1_req_we = 0, p1_rsp_valid, p1_rsp_ready = 1, p1_rsp_err;
  logic [AW-1:0] p1_req_addr = 0;
  logic [DW-1:0] p1_req_wdata = 0, p1_rsp_rdata;
  logic [TW-1:0] p1_req_dtype = 0;
  logic [AW-1:0] lsu_addr_o;
  logic [DW-1:0] lsu_data_o, lsu_data_i;
  logic          lsu_we_o;
  logic [TW-1:0] lsu_dtype_o;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic ref_ptr = 1'b0;
  logic mem_clear = 1'b0;
  logic [7:0] lmem [0:4095];
  logic [7:0] ref_mem [0:4095];

  always #5 clk = ~clk;

  lsu_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DTYPE_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_req_we(p0_req_we), .p0_req_dtype(p0_req_dtype),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
    .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_req_we(p1_req_we), .p1_req_dtype(p1_req_dtype),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
    .p1_rsp_err(p1_rsp_err),
    .lsu_addr_o(lsu_addr_o), .lsu_data_o(lsu_data_o), .lsu_we_o(lsu_we_o),
    .lsu_dtype_o(lsu_dtype_o), .lsu_data_i(lsu_data_i)
  );

  // Little-endian 4-byte window shaped by load dtype.
  function automatic logic [31:0] shape(input logic [31:0] w, input logic [2:0] dt);
    case (dt)
      3'd0: return {{24{w[7]}}, w[7:0]};
      3'd1: return {{16{w[15]}}, w[15:0]};
      3'd3: return {24'd0, w[7:0]};
      3'd4: return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] lsu_word(input logic [11:0] a);
    return {lmem[a + 12'd3], lmem[a + 12'd2], lmem[a + 12'd1], lmem[a]};
  endfunction

  // LSU: synchronous write, one-cycle registered read.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) lmem[i] <= 8'h00;
    end else if (lsu_we_o) begin
      lmem[lsu_addr_o] <= lsu_data_o[7:0];
      if (lsu_dtype_o == 3'd1 || lsu_dtype_o == 3'd4 || lsu_dtype_o == 3'd2)
        lmem[lsu_addr_o + 12'd1] <= lsu_data_o[15:8];
      if (lsu_dtype_o == 3'd2) begin
        lmem[lsu_addr_o + 12'd2] <= lsu_data_o[23:16];
        lmem[lsu_addr_o + 12'd3] <= lsu_data_o[31:24];
      end
    end
    lsu_data_i <= shape(lsu_word(lsu_addr_o), lsu_dtype_o);
  end

  function automatic logic ref_err(input logic [11:0] a, input logic [2:0] t);
    if (t > 3'd4) return 1'b1;
    if ((t == 3'd1 || t == 3'd4) && a[0]) return 1'b1;
    if (t == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  task automatic ref_apply(input logic [11:0] a, input logic [31:0] d, input logic w, input logic [2:0] t,
                           output logic [31:0] erd, output logic eer);
    int nb;
    eer = ref_err(a, t);
    erd = 32'd0;
    if (!eer && w) begin
      nb = (t == 3'd2) ? 4 : ((t == 3'd1 || t == 3'd4) ? 2 : 1);
      for (int i = 0; i < nb; i++) ref_mem[a + 12'(i)] = d[8*i +: 8];
    end else if (!eer) begin
      erd = shape({ref_mem[a + 12'd3], ref_mem[a + 12'd2], ref_mem[a + 12'd1], ref_mem[a]}, t);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [11:0] a, input logic [31:0] d,
                         input logic w, input logic [2:0] t);
    if (p == 0) begin
      p0_req_valid = v; p0_req_addr = a; p0_req_wdata = d; p0_req_we = w; p0_req_dtype = t;
    end else begin
      p1_req_valid = v; p1_req_addr = a; p1_req_wdata = d; p1_req_we = w; p1_req_dtype = t;
    end
  endtask

  // Drives one request and collects the observed response; the caller compares.
  task automatic run_txn(input int p, input logic [11:0] a, input logic [31:0] d, input logic w,
                         input logic [2:0] t, output logic tout, output int lat,
                         output logic [31:0] rd, output logic er, output logic we_seen);
    logic acc, got;
    int n;
    tout = 1'b0; lat = -1; rd = 32'hx; er = 1'bx; we_seen = 1'b0; acc = 1'b0; got = 1'b0;
    p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
    set_req(p, 1'b1, a, d, w, t);
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = (p == 0) ? p0_req_ready : p1_req_ready;
      @(posedge clk); #1;
    end
    set_req(p, 1'b0, 12'd0, 32'd0, 1'b0, 3'd0);
    if (!acc) begin
      tout = 1'b1;
      return;
    end
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (lsu_we_o) we_seen = 1'b1;
      if ((p == 0) ? p0_rsp_valid : p1_rsp_valid) begin
        got = 1'b1; lat = n;
        rd = (p == 0) ? p0_rsp_rdata : p1_rsp_rdata;
        er = (p == 0) ? p0_rsp_err : p1_rsp_err;
      end
      @(posedge clk); #1;
    end
    if (!got) tout = 1'b1;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ref_ptr = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_clear = 1'b1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    p0_req_valid = 1'b1; p1_req_valid = 1'b1;
    @(posedge clk); #1;
    mem_clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_cnt++;
      if ({p1_req_ready, p0_req_ready} !== 2'b00)
        $display("FAIL reset_req_ready: got %b expected 00", {p1_req_ready, p0_req_ready});
      else pass_cnt++;
      @(posedge clk); #1;
    end
    p0_req_valid = 1'b0; p1_req_valid = 1'b0; reset = 1'b0; ref_ptr = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err, lsu_we_o} !== 7'd0)
      $display("FAIL reset_flags: got %b expected 0000000",
               {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err, lsu_we_o});
    else pass_cnt++;
    chk_cnt++;
    if ({p0_rsp_rdata, p1_rsp_rdata, lsu_addr_o, lsu_data_o, lsu_dtype_o} !== {64'd0, 12'd0, 32'd0, 3'd2})
      $display("FAIL reset_values: got rdata %h/%h addr %h data %h dtype %0d expected 0/0/0/0/2",
               p0_rsp_rdata, p1_rsp_rdata, lsu_addr_o, lsu_data_o, lsu_dtype_o);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  // Issues one transaction and compares status and data against the shadow model.
  task automatic test_txn(input string name, input int p, input logic [11:0] a, input logic [31:0] d,
                          input logic w, input logic [2:0] t);
    logic tout, er, ws, eer;
    logic [31:0] rd, erd;
    int lat;
    ref_apply(a, d, w, t, erd, eer);
    run_txn(p, a, d, w, t, tout, lat, rd, er, ws);
    ref_ptr = (p == 0);
    chk_cnt++;
    if ({tout, 8'(lat), er, ws} !== {1'b0, 8'd3, eer, w & ~eer})
      $display("FAIL %s_status: got tout=%b lat=%0d err=%b we=%b expected tout=0 lat=3 err=%b we=%b",
               name, tout, lat, er, ws, eer, w & ~eer);
    else pass_cnt++;
    chk_cnt++;
    if (rd !== erd) $display("FAIL %s_rdata: got %h expected %h", name, rd, erd);
    else pass_cnt++;
  endtask

  task automatic test_store_load;
    test_txn("st_word", 0, 12'h010, 32'hDEADBEEF, 1'b1, 3'd2);
    test_txn("ld_word", 0, 12'h010, 32'h0, 1'b0, 3'd2);
  endtask

  task automatic test_signed_byte;
    test_txn("st_byte", 0, 12'h021, 32'h00000080, 1'b1, 3'd0);
    test_txn("ld_sbyte", 0, 12'h021, 32'h0, 1'b0, 3'd0);
    test_txn("ld_ubyte", 0, 12'h021, 32'h0, 1'b0, 3'd3);
  endtask

  task automatic test_misaligned;
    test_txn("st_misal", 0, 12'h013, 32'h12345678, 1'b1, 3'd2);
    test_txn("ld_after_misal", 0, 12'h010, 32'h0, 1'b0, 3'd2);
  endtask

  task automatic test_backpressure;
    logic [31:0] e1, e0;
    logic r1, r0, acc, got;
    int n;
    ref_apply(12'h010, 32'h0, 1'b0, 3'd2, e1, r1);
    p1_rsp_ready = 1'b0;
    set_req(1, 1'b1, 12'h010, 32'h0, 1'b0, 3'd2);
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk); acc = p1_req_ready;
      @(posedge clk); #1;
    end
    set_req(1, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0);
    set_req(0, 1'b1, 12'h021, 32'h0, 1'b0, 3'd3);
    ref_ptr = 1'b0;
    n = 0; got = 1'b0;
    while (acc && !got && n < 10) begin
      @(negedge clk); n++;
      if (p1_rsp_valid) got = 1'b1;
      else begin
        chk_cnt++;
        if (p0_req_ready !== 1'b0) $display("FAIL bp_early_grant: got %b expected 0", p0_req_ready);
        else pass_cnt++;
        @(posedge clk); #1;
      end
    end
    chk_cnt++;
    if ({acc, got, 8'(n)} !== {1'b1, 1'b1, 8'd3})
      $display("FAIL bp_latency: got acc=%b rsp=%b lat=%0d expected 1 1 3", acc, got, n);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk_cnt++;
      if ({p1_rsp_valid, p0_req_ready, p1_rsp_err, p1_rsp_rdata} !== {1'b1, 1'b0, r1, e1})
        $display("FAIL bp_hold: got valid=%b p0_ready=%b err=%b rdata=%h expected 1 0 %b %h",
                 p1_rsp_valid, p0_req_ready, p1_rsp_err, p1_rsp_rdata, r1, e1);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    p1_rsp_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({p1_rsp_valid, p0_req_ready} !== 2'b10)
      $display("FAIL bp_handshake: got valid=%b p0_ready=%b expected 1 0", p1_rsp_valid, p0_req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    chk_cnt++;
    if ({p1_rsp_valid, p0_req_ready} !== 2'b01)
      $display("FAIL bp_p0_accept: got p1_valid=%b p0_ready=%b expected 0 1", p1_rsp_valid, p0_req_ready);
    else pass_cnt++;
    ref_apply(12'h021, 32'h0, 1'b0, 3'd3, e0, r0);
    ref_ptr = 1'b1;
    @(posedge clk); #1;
    set_req(0, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0);
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      if (p0_rsp_valid) got = 1'b1;
      @(posedge clk); #1;
    end
    chk_cnt++;
    if ({got, 8'(n), p0_rsp_rdata, p0_rsp_err} !== {1'b1, 8'd3, e0, r0})
      $display("FAIL bp_p0_rsp: got rsp=%b lat=%0d rdata=%h err=%b expected 1 3 %h %b",
               got, n, p0_rsp_rdata, p0_rsp_err, e0, r0);
    else pass_cnt++;
  endtask

  task automatic test_arbitration;
    logic [11:0] a [2];
    logic [31:0] d [2];
    logic        w [2];
    logic [31:0] erd;
    logic        eer, busy, bp, acc_now;
    logic [1:0]  exp_rdy, exp_rsp;
    int grants, age, cyc;
    pulse_reset;
    for (int p = 0; p < 2; p++) begin
      a[p] = 12'h300 + 12'(4 * $urandom_range(0, 15)); d[p] = $urandom; w[p] = 1'($urandom_range(0, 1));
      set_req(p, 1'b1, a[p], d[p], w[p], 3'd2);
    end
    grants = 0; age = 0; cyc = 0; busy = 1'b0; bp = 1'b0;
    erd = 32'd0; eer = 1'b0;
    while (cyc < 60 && !(grants == 4 && !busy)) begin
      @(negedge clk); cyc++; acc_now = 1'b0;
      if (busy) age++;
      if (busy) exp_rdy = 2'b00;
      else if (p0_req_valid && p1_req_valid) exp_rdy = ref_ptr ? 2'b10 : 2'b01;
      else exp_rdy = {p1_req_valid, p0_req_valid};
      chk_cnt++;
      if ({p1_req_ready, p0_req_ready} !== exp_rdy)
        $display("FAIL arb_ready: got %b expected %b (grant %0d)", {p1_req_ready, p0_req_ready}, exp_rdy, grants);
      else pass_cnt++;
      exp_rsp = (busy && age == 3) ? (bp ? 2'b10 : 2'b01) : 2'b00;
      chk_cnt++;
      if ({p1_rsp_valid, p0_rsp_valid} !== exp_rsp)
        $display("FAIL arb_rsp_valid: got %b expected %b", {p1_rsp_valid, p0_rsp_valid}, exp_rsp);
      else pass_cnt++;
      if (busy && age == 3) begin
        chk_cnt++;
        if ((bp ? {p1_rsp_rdata, p1_rsp_err} : {p0_rsp_rdata, p0_rsp_err}) !== {erd, eer})
          $display("FAIL arb_rsp_data: got %h/%b expected %h/%b", bp ? p1_rsp_rdata : p0_rsp_rdata,
                   bp ? p1_rsp_err : p0_rsp_err, erd, eer);
        else pass_cnt++;
        busy = 1'b0;
      end else if (!busy && exp_rdy != 2'b00) begin
        bp = exp_rdy[1];
        chk_cnt++;
        if (p1_req_ready !== 1'(grants % 2))
          $display("FAIL arb_alternate: got p1_ready=%b expected %0d at grant %0d", p1_req_ready, grants % 2, grants);
        else pass_cnt++;
        ref_apply(a[bp], d[bp], w[bp], 3'd2, erd, eer);
        ref_ptr = ~bp; busy = 1'b1; age = 0; grants++; acc_now = 1'b1;
      end
      @(posedge clk); #1;
      if (acc_now) begin
        if (grants < 4) begin
          a[bp] = 12'h300 + 12'(4 * $urandom_range(0, 15)); d[bp] = $urandom; w[bp] = 1'($urandom_range(0, 1));
          set_req(int'(bp), 1'b1, a[bp], d[bp], w[bp], 3'd2);
        end else begin
          set_req(0, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0);
          set_req(1, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0);
        end
      end
    end
    chk_cnt++;
    if ({8'(grants), busy} !== {8'd4, 1'b0})
      $display("FAIL arb_progress: got grants=%0d busy=%b expected 4 0", grants, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic acc;
    test_txn("st_old", 0, 12'h040, 32'h11223344, 1'b1, 3'd2);
    set_req(0, 1'b1, 12'h040, 32'hCAFEBABE, 1'b1, 3'd2);
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk); acc = p0_req_ready;
      @(posedge clk); #1;
    end
    chk_cnt++;
    if (acc !== 1'b1) $display("FAIL rmid_accept: got %b expected 1", acc);
    else pass_cnt++;
    reset = 1'b1;
    set_req(0, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0);
    @(negedge clk);
    chk_cnt++;
    if (lsu_we_o !== 1'b0) $display("FAIL rmid_we_gate: got %b expected 0", lsu_we_o);
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0; ref_ptr = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err, lsu_we_o, p0_rsp_rdata, p1_rsp_rdata,
         lsu_addr_o, lsu_data_o, lsu_dtype_o} !== {5'd0, 64'd0, 12'd0, 32'd0, 3'd2})
      $display("FAIL rmid_outputs: got valid=%b%b err=%b%b we=%b rdata=%h/%h addr=%h data=%h dtype=%0d expected zeros dtype 2",
               p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err, lsu_we_o, p0_rsp_rdata, p1_rsp_rdata,
               lsu_addr_o, lsu_data_o, lsu_dtype_o);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk_cnt++;
      if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00)
        $display("FAIL rmid_no_rsp: got %b%b expected 00", p0_rsp_valid, p1_rsp_valid);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    test_txn("ld_after_rst", 0, 12'h040, 32'h0, 1'b0, 3'd2);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      test_txn("rand", int'($urandom_range(0, 1)), 12'h200 | 12'($urandom_range(0, 255)), $urandom,
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)));
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_store_load;
    test_signed_byte;
    test_misaligned;
    test_backpressure;
    test_arbitration;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
